// File: rtl/partoserial_tx.sv
// Parallel-to-serial PHY transmitter: 8-bit words out MSB first,
// with a COMMA training burst after reset and COMMA fill on idle frames.
module partoserial_tx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned SYNC_FRAMES = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_par,
  input  logic       valid_par,
  output logic       ready_par,
  output logic       data_out,
  output logic       frame_start,
  output logic       tx_active
);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       frame_start_q, frame_start_d;
  logic       tx_active_q, tx_active_d;
  logic       load;

  assign load        = (bit_cnt_q == 3'd7);
  assign ready_par   = (state_q == RUN) && load;
  assign data_out    = shreg_q[7];
  assign frame_start = frame_start_q;
  assign tx_active   = tx_active_q;

  always_comb begin
    state_d       = state_q;
    shreg_d       = {shreg_q[6:0], 1'b0};
    bit_cnt_d     = bit_cnt_q + 3'd1;
    sync_cnt_d    = sync_cnt_q;
    frame_start_d = 1'b0;
    tx_active_d   = tx_active_q;
    if (load) begin
      frame_start_d = 1'b1;
      unique case (state_q)
        SYNC: begin
          shreg_d    = COMMA;
          sync_cnt_d = sync_cnt_q + 4'd1;
          if (sync_cnt_q == SYNC_LAST) begin
            state_d     = RUN;
            tx_active_d = 1'b1;
          end
        end
        RUN: begin
          shreg_d = valid_par ? data_par : COMMA;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q       <= SYNC;
      shreg_q       <= 8'h00;
      bit_cnt_q     <= 3'd7;
      sync_cnt_q    <= 4'd0;
      frame_start_q <= 1'b0;
      tx_active_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      sync_cnt_q    <= sync_cnt_d;
      frame_start_q <= frame_start_d;
      tx_active_q   <= tx_active_d;
    end
  end

endmodule

// File: tb/tb_partoserial_tx.sv
// Bench for partoserial_tx: frame-schedule reference model plus
// a COMMA-dropping receiver model fed from data_out.
module tb_partoserial_tx;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         SF    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_par;
  logic       valid_par;
  logic       ready_par;
  logic       data_out;
  logic       frame_start;
  logic       tx_active;

  partoserial_tx #(
    .COMMA(COMMA),
    .SYNC_FRAMES(SF)
  ) dut (
    .clk_8f(clk),
    .reset(reset),
    .data_par(data_par),
    .valid_par(valid_par),
    .ready_par(ready_par),
    .data_out(data_out),
    .frame_start(frame_start),
    .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         e     = -1;
  bit         armed = 1'b0;
  logic [7:0] fr    = 8'h00;
  logic [7:0] rx    = 8'h00;
  logic [7:0] sent_q[$];

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h e=%0d t=%0t",
               tag, got, exp, e, $time);
    end
  endtask

  function automatic logic [7:0] rand_word();
    logic [7:0] w;
    do w = 8'($urandom); while (w == COMMA);
    return w;
  endfunction

  task automatic step(input logic r, input logic v,
                      input logic [7:0] d);
    int nxt;
    int idx;
    logic [7:0] exp_w;
    reset     = r;
    valid_par = v;
    data_par  = d;
    @(negedge clk);
    nxt = e + 1;
    if (armed)
      check("ready_par", {7'd0, ready_par},
            {7'd0, (nxt % 8 == 0) && (nxt / 8 >= SF)});
    @(posedge clk);
    if (r) begin
      e     = -1;
      armed = 1'b1;
      rx    = 8'h00;
      sent_q.delete();
      #1;
      check("rst_data_out", {7'd0, data_out}, 8'd0);
      check("rst_frame_start", {7'd0, frame_start}, 8'd0);
      check("rst_tx_active", {7'd0, tx_active}, 8'd0);
      check("rst_ready", {7'd0, ready_par}, 8'd0);
    end else begin
      e = e + 1;
      if (e % 8 == 0) begin
        if (e / 8 >= SF && v) begin
          fr = d;
          sent_q.push_back(d);
        end else begin
          fr = COMMA;
        end
      end
      idx = 7 - (e % 8);
      #1;
      check("data_out", {7'd0, data_out}, {7'd0, fr[idx]});
      check("frame_start", {7'd0, frame_start},
            {7'd0, e % 8 == 0});
      check("tx_active", {7'd0, tx_active},
            {7'd0, e >= 8 * (SF - 1)});
      rx = {rx[6:0], data_out};
      if (e % 8 == 7 && rx != COMMA) begin
        if (sent_q.size() == 0) begin
          check("rx_extra", rx, COMMA);
        end else begin
          exp_w = sent_q.pop_front();
          check("rx_word", rx, exp_w);
        end
      end
    end
  endtask

  task automatic align();
    while ((e + 1) % 8 != 0) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d);
    align();
    step(1'b0, 1'b1, d);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 8'($urandom));
  endtask

  initial begin
    reset     = 1'b1;
    valid_par = 1'b0;
    data_par  = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 48; i++) step(1'b0, 1'b0, 8'h00);

    send(8'hA5);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00);

    send(8'h01);
    send(8'hFF);
    send(8'h3C);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 48; i++)
      step(1'b0, ((e + 1) % 8 != 0) ? 1'($urandom) : 1'b0,
           rand_word());

    align();
    step(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 48; i++) step(1'b0, 1'b1, rand_word());

    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap * 8; g++) step(1'b0, 1'b0, 8'h00);
      send(rand_word());
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00);
    check("rx_left", 8'(sent_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
